// File: rtl/instr_stream_encoder_if.sv
// Command handshake and instruction-memory write bus for instr_stream_encoder.
// The slave side is the encoder; the master side issues commands and observes writes.
interface instr_stream_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_kind;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  cmd_valid, cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output cmd_valid, cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// Encodes symbolic RV64I/Zba commands into 32-bit words and writes them to
// consecutive imem slots, one command every two cycles, until DEPTH words are written.
module instr_stream_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    parameter int          CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    instr_stream_encoder_if.slave bus,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 err,
    output logic [1:0]           err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        kind_q, kind_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [31:0]       enc;
    logic [1:0]        rej;
    logic [6:0]        r_f7;
    logic [2:0]        r_f3;
    logic              i_ok, b_ok, j_ok;
    logic              do_write;

    // Encoder over the latched command; rej is 0 for a legal command, else the rejection code.
    always_comb begin
        enc  = '0;
        rej  = 2'd0;
        r_f7 = 7'b0000000;
        r_f3 = 3'b000;
        i_ok = (imm_q == {{20{imm_q[11]}}, imm_q[11:0]});
        b_ok = (imm_q == {{19{imm_q[12]}}, imm_q[12:0]});
        j_ok = (imm_q == {{11{imm_q[20]}}, imm_q[20:0]});
        case (kind_q)
            4'd0: begin
                enc = {imm_q[11:0], rs1_q, 3'b011, rd_q, 7'b0000011};
                if (!i_ok) rej = 2'd2;
            end
            4'd1: begin
                enc = {imm_q[11:5], rs2_q, rs1_q, 3'b011, imm_q[4:0], 7'b0100011};
                if (!i_ok) rej = 2'd2;
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                case (kind_q)
                    4'd3:    begin r_f7 = 7'b0100000; r_f3 = 3'b000; end
                    4'd4:    begin r_f7 = 7'b0000000; r_f3 = 3'b111; end
                    4'd5:    begin r_f7 = 7'b0000000; r_f3 = 3'b110; end
                    4'd6:    begin r_f7 = 7'b0010000; r_f3 = 3'b010; end
                    4'd7:    begin r_f7 = 7'b0010000; r_f3 = 3'b100; end
                    4'd8:    begin r_f7 = 7'b0010000; r_f3 = 3'b110; end
                    default: begin r_f7 = 7'b0000000; r_f3 = 3'b000; end
                endcase
                enc = {r_f7, rs2_q, rs1_q, r_f3, rd_q, 7'b0110011};
            end
            4'd9: begin
                enc = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
                if (!i_ok) rej = 2'd2;
            end
            4'd10: begin
                enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                       imm_q[4:1], imm_q[11], 7'b1100011};
                if (imm_q[0])  rej = 2'd3;
                else if (!b_ok) rej = 2'd2;
            end
            4'd11: begin
                enc = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
                if (imm_q[0])  rej = 2'd3;
                else if (!j_ok) rej = 2'd2;
            end
            default: rej = 2'd1;
        endcase
    end

    // A clear in the EMIT cycle suppresses the strobe combinationally.
    assign do_write       = (state_q == EMIT) && (rej == 2'd0) && !clear;
    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.imem_we    = do_write;
    assign bus.imem_addr  = do_write ? ptr_q : addr_q;
    assign bus.imem_wdata = do_write ? enc : wdata_q;
    assign count          = count_q;
    assign full           = (count_q == CNT_W'(DEPTH));
    assign err            = err_q;
    assign err_code       = err_code_q;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (clear) begin
            state_d    = IDLE;
            ptr_d      = BASE_ADDR;
            count_d    = '0;
            err_d      = 1'b0;
            err_code_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        kind_d  = bus.cmd_kind;
                        rd_d    = bus.cmd_rd;
                        rs1_d   = bus.cmd_rs1;
                        rs2_d   = bus.cmd_rs2;
                        imm_d   = bus.cmd_imm;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (rej == 2'd0) begin
                        addr_d  = ptr_q;
                        wdata_d = enc;
                        ptr_d   = ptr_q + 32'd4;
                        count_d = count_q + CNT_W'(1);
                        state_d = (count_q + CNT_W'(1) == CNT_W'(DEPTH)) ? FULL : IDLE;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = rej;
                        state_d    = IDLE;
                    end
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            kind_q     <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            ptr_q      <= BASE_ADDR;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

endmodule
